had_inverse_sink: RTL and testbench
===================================

# had_inverse_sink

Receive end of the 4-point Hadamard path. It accepts one block of four signed Hadamard coefficients over a valid/ready stream and applies the inverse transform (H·X/4). It then returns the four reconstructed unsigned samples serially over a second valid/ready stream. It sits downstream of the transform's output FIFO and recovers the `din` sample stream written into `had_transform_source`.

## Interface
- `DW`, default 4: reconstructed sample width (unsigned), matching the source `din` width.
- `CW`, default `DW+3`: coefficient width (signed two's complement); holds the forward-transform range.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `coef_in`  in  CW  signed coefficient; block order X0, X1, X2, X3 (Sylvester row order).
- `coef_valid`  in  1  `coef_in` is valid.
- `coef_ready`  out  1  block can accept a coefficient.
- `dout`  out  DW  reconstructed sample; order x0..x3.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  consumer accepts `dout`.
- `err`  out  1  the current `dout` was inexact or clamped; qualified by `dout_valid`.

## Operation
- States:
  - `COLLECT`: `coef_ready`=1. Each coef handshake writes `X[cnt]` and increments the 2-bit `cnt`. The handshake with `cnt`=3 goes to `BFLY1` and wraps `cnt` to 0.
  - `BFLY1`: one cycle.
    - `a0`=X0+X1, `a1`=X0−X1, `a2`=X2+X3, `a3`=X2−X3, each `CW+1` bits signed, registered.
  - `BFLY2`: one cycle.
    - `s0`=a0+a2, `s1`=a1+a3, `s2`=a0−a2, `s3`=a1−a3, each `CW+2` bits signed.
    - Each `s` is arithmetic-shifted right by 2.
    - Each result is clamped to [0, 2^DW−1], then registered into the output buffer with a per-sample err bit.
    - err bit = (s[1:0]≠0) OR clamped.
    - Go to `EMIT`.
  - `EMIT`: `dout_valid`=1, with `dout`/`err` taken from `buf[cnt]`. Each output handshake increments `cnt`. The handshake with `cnt`=3 returns to `COLLECT` and wraps `cnt` to 0.
- `coef_ready`=0 in `BFLY1`, `BFLY2` and `EMIT`. Coefficients presented there are not consumed; upstream holds them.
- `dout_ready` low in `EMIT` stalls. `dout`, `err` and `cnt` hold stable until the handshake.
- `coef_valid` gaps in `COLLECT` are allowed; partial blocks wait indefinitely.
- Reset values: state=`COLLECT`, `cnt`=0, `coef_ready`=1 only after the first post-reset edge.
- Reset values for outputs: `dout_valid`=0, `dout`=0, `err`=0. X, a and buffer registers are cleared to 0.
- Reset mid-block, in any state, discards the partial block or any unsent outputs. No output is emitted for it.

## Timing
- Coefficient accepted at edge t when `coef_valid` & `coef_ready`. Output handshake at edge t when `dout_valid` & `dout_ready`.
- Last coef (X3) accepted at edge t: `BFLY1` during t..t+1, `BFLY2` during t+1..t+2. `dout_valid`=1 with x0 from edge t+2 onward, so latency is 2 cycles.
- With `dout_ready` held at 1: x0..x3 appear on 4 consecutive cycles. `coef_ready` rises the cycle after the x3 handshake.
- Throughput with no stalls: 4 in + 2 compute + 4 out = 10 cycles per block.
- No combinational path from `dout_ready` to `coef_ready`, or from `coef_valid` to `dout_valid`.

## Structure
- Shared package `had_pkg` holds:
  - the `DW` and `CW` defaults;
  - the state enum `{COLLECT, BFLY1, BFLY2, EMIT}`;
  - the point count constant `HAD_N`=4;
  - the shift constant `HAD_LOG2N`=2.
- One sub-module, `had_bfly2`: a combinational radix-2 butterfly (sum and difference, input width parameter, output one bit wider). Instantiate it twice per stage, four in total; stage registers stay in the top.
- Estimated RTL size: ~180 lines top, ~25 lines sub-module.

## Test plan
- Constant block: coefs 48,0,0,0 with `dout_ready`=1. Required: `dout` 12,12,12,12 on 4 consecutive cycles, `err`=0, first one exactly 2 cycles after the X3 accept.
- Ramp block: coefs 10,−2,−4,0. Required: `dout` 1,2,3,4, `err`=0.
- Backpressure: repeat the ramp block with `dout_ready` low 3 cycles before each sample. Required: `dout` holds each value while stalled; `coef_ready`=0 until after the x3 handshake; no coef consumed early.
- Inexact and clamp: coefs 1,0,0,0 gives `dout` 0,0,0,0 with `err`=1 on all four. Coefs 63,63,0,0 gives s0=126, so x0 clamps to 15 with `err`=1.
- Gapped input and back-to-back blocks: coef_valid toggled every other cycle across two blocks (48,0,0,0 then 10,−2,−4,0). Required: outputs 12,12,12,12,1,2,3,4 in order, none dropped or duplicated.
- Reset mid-operation: assert `rst` for 1 cycle after 2 coefs accepted, then separately during `EMIT` after x1. Required: `dout_valid`=0 the next cycle, `cnt` back to 0, and the next full block reconstructs correctly.

Source files
------------

// File: rtl/had_pkg.sv
// rtl/had_pkg.sv - shared constants and state type for the 4-point Hadamard path
package had_pkg;

  localparam int HAD_DW    = 4;
  localparam int HAD_CW    = HAD_DW + 3;
  localparam int HAD_N     = 4;
  localparam int HAD_LOG2N = 2;

  typedef enum logic [1:0] {
    COLLECT,
    BFLY1,
    BFLY2,
    EMIT
  } had_state_e;

endpackage

// File: rtl/had_bfly2.sv
// rtl/had_bfly2.sv - combinational radix-2 butterfly, output one bit wider than input
module had_bfly2 #(
  parameter int W = 7
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W:0]   sum,
  output logic signed [W:0]   diff
);

  // Sign-extend before the add so the carry lands in the extra bit.
  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;

  assign a_ext = {a[W-1], a};
  assign b_ext = {b[W-1], b};
  assign sum   = a_ext + b_ext;
  assign diff  = a_ext - b_ext;

endmodule

// File: rtl/had_inverse_sink.sv
// rtl/had_inverse_sink.sv - collects four Hadamard coefficients, inverts, emits four clamped samples
module had_inverse_sink
  import had_pkg::*;
#(
  parameter int DW = HAD_DW,
  parameter int CW = DW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [CW-1:0] coef_in,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  output logic [DW-1:0]        dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 err
);

  localparam logic signed [CW+1:0] MAXV = (CW+2)'((1 << DW) - 1);

  had_state_e state, state_next;
  logic [1:0] cnt;

  logic signed [CW-1:0] x_reg   [HAD_N];
  logic signed [CW:0]   a_reg   [HAD_N];
  logic signed [CW:0]   a_next  [HAD_N];
  logic signed [CW+1:0] s_val   [HAD_N];
  logic signed [CW+1:0] q_val   [HAD_N];
  logic [DW-1:0]        c_val   [HAD_N];
  logic [HAD_N-1:0]     c_err;
  logic [DW-1:0]        out_buf [HAD_N];
  logic [HAD_N-1:0]     out_err;

  logic coef_fire;
  logic dout_fire;

  had_bfly2 #(.W(CW)) u_b1_lo (.a(x_reg[0]), .b(x_reg[1]), .sum(a_next[0]), .diff(a_next[1]));
  had_bfly2 #(.W(CW)) u_b1_hi (.a(x_reg[2]), .b(x_reg[3]), .sum(a_next[2]), .diff(a_next[3]));

  // Second stage pairs the sums with each other and the differences with each other.
  had_bfly2 #(.W(CW+1)) u_b2_ev (.a(a_reg[0]), .b(a_reg[2]), .sum(s_val[0]), .diff(s_val[2]));
  had_bfly2 #(.W(CW+1)) u_b2_od (.a(a_reg[1]), .b(a_reg[3]), .sum(s_val[1]), .diff(s_val[3]));

  always_comb begin
    for (int i = 0; i < HAD_N; i++) begin
      q_val[i] = s_val[i] >>> HAD_LOG2N;
      c_val[i] = q_val[i][DW-1:0];
      c_err[i] = (s_val[i][HAD_LOG2N-1:0] != '0);
      if (q_val[i][CW+1]) begin
        c_val[i] = '0;
        c_err[i] = 1'b1;
      end else if (q_val[i] > MAXV) begin
        c_val[i] = '1;
        c_err[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    coef_ready = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    err        = 1'b0;
    case (state)
      COLLECT: begin
        coef_ready = 1'b1;
        if (coef_valid && cnt == 2'd3) state_next = BFLY1;
      end
      BFLY1: state_next = BFLY2;
      BFLY2: state_next = EMIT;
      EMIT: begin
        dout_valid = 1'b1;
        dout       = out_buf[cnt];
        err        = out_err[cnt];
        if (dout_ready && cnt == 2'd3) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  assign coef_fire = coef_valid && coef_ready;
  assign dout_fire = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 2'd0;
      out_err <= '0;
      for (int i = 0; i < HAD_N; i++) begin
        x_reg[i]   <= '0;
        a_reg[i]   <= '0;
        out_buf[i] <= '0;
      end
    end else begin
      if (coef_fire) begin
        x_reg[cnt] <= coef_in;
        cnt        <= cnt + 2'd1;
      end
      if (state == BFLY1) begin
        for (int i = 0; i < HAD_N; i++) a_reg[i] <= a_next[i];
      end
      if (state == BFLY2) begin
        for (int i = 0; i < HAD_N; i++) out_buf[i] <= c_val[i];
        out_err <= c_err;
      end
      if (dout_fire) cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_had_inverse_sink.sv
// tb/tb_had_inverse_sink.sv - scoreboard bench for had_inverse_sink
module tb_had_inverse_sink;

  localparam int DW = 4;
  localparam int CW = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [CW-1:0] coef_in = '0;
  logic                 coef_valid = 1'b0;
  logic                 coef_ready;
  logic [DW-1:0]        dout;
  logic                 dout_valid;
  logic                 dout_ready = 1'b1;
  logic                 err;

  had_inverse_sink #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int e;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   stall_mode = 0;
  int   hs_count = 0;
  int   hs_seen = 0;
  int   wait_cnt = 0;
  int   blk_id = 0;
  int   lat_done_id = 0;
  int   lat_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_block(input int c0, input int c1, input int c2, input int c3);
    int s[4];
    exp_t e;
    s[0] = c0 + c1 + c2 + c3;
    s[1] = c0 - c1 + c2 - c3;
    s[2] = c0 + c1 - c2 - c3;
    s[3] = c0 - c1 - c2 + c3;
    for (int i = 0; i < 4; i++) begin
      e.d = s[i] >>> 2;
      e.e = ((s[i] & 3) != 0) ? 1 : 0;
      if (e.d < 0) begin
        e.d = 0;
        e.e = 1;
      end else if (e.d > 15) begin
        e.d = 15;
        e.e = 1;
      end
      sb.push_back(e);
    end
  endtask

  // Drives the first n coefficients of a block; only a full block is scored.
  task automatic send_block(input int c0, input int c1, input int c2, input int c3,
                            input bit gap, input int n);
    int c[4];
    int k;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < n; i++) begin
      coef_in    = CW'(c[i]);
      coef_valid = 1'b1;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!coef_ready && k < 300);
      if (!coef_ready) check("coef_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (i == 3) begin
        push_block(c0, c1, c2, c3);
        lat_exp = cyc + 2;
        blk_id++;
      end
      if (gap) begin
        coef_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    lat_done_id = blk_id;
    check("post_reset_dout_valid", dout_valid, 0);
    check("post_reset_coef_ready", coef_ready, 1);
    check("post_reset_dout", dout, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      check("coef_ready_while_emitting", coef_ready, 0);
      if (lat_done_id != blk_id) begin
        check("first_sample_latency", cyc, lat_exp);
        lat_done_id = blk_id;
      end
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else if (dout_ready) begin
        mon_e = sb.pop_front();
        check("dout", dout, mon_e.d);
        check("err", err, mon_e.e);
        hs_count++;
      end else begin
        check("stall_hold_dout", dout, sb[0].d);
        check("stall_hold_err", err, sb[0].e);
      end
    end
  end

  // Consumer holds dout_ready low for three valid cycles before each sample when stalling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs_count != hs_seen) begin
        hs_seen  = hs_count;
        wait_cnt = 0;
      end
      if (!stall_mode) begin
        dout_ready = 1'b1;
      end else if (dout_valid && wait_cnt < 3) begin
        dout_ready = 1'b0;
        wait_cnt++;
      end else begin
        dout_ready = (wait_cnt >= 3);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check("reset_coef_ready", coef_ready, 1);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_err", err, 0);
    #1;
    rst = 1'b0;

    send_block(48, 0, 0, 0, 0, 4);
    coef_valid = 1'b0;
    drain();
    send_block(10, -2, -4, 0, 0, 4);
    coef_valid = 1'b0;
    drain();

    stall_mode = 1'b1;
    send_block(10, -2, -4, 0, 0, 4);
    send_block(48, 0, 0, 0, 0, 4);
    coef_valid = 1'b0;
    drain();
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    send_block(1, 0, 0, 0, 0, 4);
    send_block(63, 63, 0, 0, 0, 4);
    send_block(-8, 0, 0, 0, 0, 4);
    send_block(7, 3, -1, 5, 0, 4);
    coef_valid = 1'b0;
    drain();

    send_block(48, 0, 0, 0, 1, 4);
    send_block(10, -2, -4, 0, 1, 4);
    coef_valid = 1'b0;
    drain();

    send_block(10, -2, -4, 0, 0, 2);
    coef_valid = 1'b0;
    pulse_reset();
    send_block(10, -2, -4, 0, 0, 4);
    coef_valid = 1'b0;
    drain();

    send_block(48, 0, 0, 0, 0, 4);
    coef_valid = 1'b0;
    begin
      int k;
      k = 0;
      while (sb.size() > 2 && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("emit_reached_x2", sb.size(), 2);
    end
    pulse_reset();
    send_block(10, -2, -4, 0, 0, 4);
    coef_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
